// File: rtl/pes_seq_det_param.sv
// Runtime-programmable serial sequence detector with valid-qualified input,
// selectable overlap and a saturating match counter.
module pes_seq_det_param #(
    parameter int unsigned           MAX_LEN = 8,
    parameter logic [MAX_LEN-1:0]    DEF_PAT = MAX_LEN'(8'h0B),
    parameter int unsigned           DEF_LEN = 4,
    parameter int unsigned           CNT_W   = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sequence_in,
    input  logic                              in_valid,
    input  logic                              cfg_load,
    input  logic [MAX_LEN-1:0]                cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]      cfg_len,
    input  logic                              cfg_overlap,
    input  logic                              count_clr,
    output logic                              detector_out,
    output logic [CNT_W-1:0]                  match_count,
    output logic                              count_sat,
    output logic                              cfg_err
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic [MAX_LEN-1:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;

    logic [MAX_LEN-1:0]   w_hist_nxt;
    logic [LEN_W-1:0]     w_fill_nxt;
    logic [LEN_W-1:0]     w_len_nxt;
    logic                 w_len_ok;
    logic                 w_cfg_take;
    logic                 w_accept;
    logic [MAX_LEN-1:0]   w_hist_sh;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_last;
    logic                 w_match;

    logic                 w_det_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_sat_nxt;
    logic                 w_err_nxt;

    // A legal configuration pre-empts any bit arriving in the same cycle.
    assign w_len_ok   = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
    assign w_cfg_take = cfg_load & w_len_ok;
    assign w_accept   = in_valid & ~w_cfg_take;
    assign w_hist_sh  = MAX_LEN'({r_hist, sequence_in});
    assign w_mask     = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - r_len);
    assign w_last     = (r_state == ST_ARMED) || ((r_fill + LEN_W'(1)) == r_len);
    assign w_match    = w_accept & w_last & (((w_hist_sh ^ r_pattern) & w_mask) == '0);
    assign w_len_nxt  = w_cfg_take ? cfg_len : r_len;

    // State register: FSM state, history, fill and live configuration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_FILL;
            r_pattern <= DEF_PAT;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            if (w_cfg_take) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
            end
        end
    end

    // Next-state: shift history, advance fill; non-overlap restarts after a hit.
    always_comb begin
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_state_nxt = r_state;
        if (w_cfg_take) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (w_accept) begin
            w_hist_nxt = w_hist_sh;
            if (w_match && !r_overlap) begin
                w_fill_nxt = '0;
            end else if (r_state == ST_ARMED) begin
                w_fill_nxt = r_len;
            end else begin
                w_fill_nxt = r_fill + LEN_W'(1);
            end
        end
        w_state_nxt = (w_fill_nxt == w_len_nxt) ? ST_ARMED : ST_FILL;
    end

    // Output decode; clear beats a simultaneous match.
    always_comb begin
        w_det_nxt = w_match;
        w_err_nxt = cfg_load & ~w_len_ok;
        w_cnt_nxt = match_count;
        if (count_clr) begin
            w_cnt_nxt = '0;
        end else if (w_match && !(&match_count)) begin
            w_cnt_nxt = match_count + CNT_W'(1);
        end
        w_sat_nxt = &w_cnt_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            detector_out <= 1'b0;
            match_count  <= '0;
            count_sat    <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            detector_out <= w_det_nxt;
            match_count  <= w_cnt_nxt;
            count_sat    <= w_sat_nxt;
            cfg_err      <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_pes_seq_det_param.sv
// Bench for pes_seq_det_param: directed scenarios plus randomized traffic
// against a queue-based model of the matching rules.
module tb_pes_seq_det_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                sequence_in = 1'b0;
    logic                in_valid = 1'b0;
    logic                cfg_load = 1'b0;
    logic [MAX_LEN-1:0]  cfg_pattern = '0;
    logic [LEN_W-1:0]    cfg_len = '0;
    logic                cfg_overlap = 1'b0;
    logic                count_clr = 1'b0;
    logic                detector_out;
    logic [CNT_W-1:0]    match_count;
    logic                count_sat;
    logic                cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [MAX_LEN-1:0]  m_pat;
    int                  m_len;
    logic                m_ov;
    logic                m_q[$];
    int                  m_cnt;
    logic                exp_det;
    logic                exp_err;
    logic [CNT_W-1:0]    exp_cnt;
    logic                exp_sat;

    pes_seq_det_param #(
        .MAX_LEN (MAX_LEN),
        .DEF_PAT (8'h0B),
        .DEF_LEN (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .count_clr    (count_clr),
        .detector_out (detector_out),
        .match_count  (match_count),
        .count_sat    (count_sat),
        .cfg_err      (cfg_err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pat = 8'h0B;
        m_len = 4;
        m_ov  = 1'b1;
        m_q.delete();
        m_cnt = 0;
        exp_det = 1'b0;
        exp_err = 1'b0;
        exp_cnt = '0;
        exp_sat = 1'b0;
    endtask

    // Drive one cycle, advance the model, then sample just after the edge.
    task automatic step(input logic b, input logic v, input logic ld,
                        input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ov, input logic clr);
        logic ok;
        sequence_in = b;
        in_valid    = v;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        count_clr   = clr;
        exp_det = 1'b0;
        exp_err = 1'b0;
        if (ld && len >= 1 && int'(len) <= MAX_LEN) begin
            m_pat = pat;
            m_len = int'(len);
            m_ov  = ov;
            m_q.delete();
        end else begin
            if (ld) exp_err = 1'b1;
            if (v) begin
                m_q.push_back(b);
                while (m_q.size() > m_len) void'(m_q.pop_front());
                if (m_q.size() == m_len) begin
                    ok = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (m_q[i] != m_pat[m_len-1-i]) ok = 1'b0;
                    if (ok) begin
                        exp_det = 1'b1;
                        if (!m_ov) m_q.delete();
                    end
                end
            end
        end
        if (clr) m_cnt = 0;
        else if (exp_det && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        exp_cnt = CNT_W'(m_cnt);
        exp_sat = (m_cnt == (1 << CNT_W) - 1);
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic b);
        step(b, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b0;
        sequence_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({detector_out, match_count, count_sat, cfg_err} !== '0)
            $display("FAIL reset_outputs: det=%b cnt=%0d sat=%b err=%b, required all 0",
                     detector_out, match_count, count_sat, cfg_err);
        else n_pass++;
        apply_reset();
        idle();
        n_checks++;
        if ({detector_out, match_count, count_sat, cfg_err} !== '0)
            $display("FAIL post_reset_idle: det=%b cnt=%0d sat=%b err=%b, required all 0",
                     detector_out, match_count, count_sat, cfg_err);
        else n_pass++;
    endtask

    task automatic test_default_overlap();
        logic [6:0] s = 7'b1011011;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            send(s[6-i]);
            n_checks++;
            if (detector_out !== (i == 3 || i == 6))
                $display("FAIL default_det bit%0d: got %b, required %b", i + 1, detector_out, (i == 3 || i == 6));
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 3'd2) $display("FAIL default_count: got %0d, required 2", match_count);
        else n_pass++;
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s = 7'b1011011;
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send(s[6-i]);
            n_checks++;
            if (detector_out !== (i == 3))
                $display("FAIL nonoverlap_det bit%0d: got %b, required %b", i + 1, detector_out, (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 3'd1) $display("FAIL nonoverlap_count: got %0d, required 1", match_count);
        else n_pass++;
    endtask

    task automatic test_gap();
        apply_reset();
        send(1'b1);
        send(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++;
            if (detector_out !== 1'b0) $display("FAIL gap_det cycle%0d: got %b, required 0", i, detector_out);
            else n_pass++;
        end
        send(1'b1);
        n_checks++;
        if (detector_out !== 1'b0) $display("FAIL gap_early: got %b, required 0", detector_out);
        else n_pass++;
        send(1'b1);
        n_checks++;
        if (detector_out !== 1'b1) $display("FAIL gap_final: got %b, required 1", detector_out);
        else n_pass++;
    endtask

    task automatic test_cfg_same_cycle();
        logic [2:0] s = 3'b110;
        apply_reset();
        send(1'b1); send(1'b0); send(1'b1);
        step(1'b1, 1'b1, 1'b1, 8'b0000_0110, 4'd3, 1'b1, 1'b0);
        n_checks++;
        if (detector_out !== 1'b0) $display("FAIL cfg_same_cycle_det: got %b, required 0", detector_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            send(s[2-i]);
            n_checks++;
            if (detector_out !== (i == 2))
                $display("FAIL cfg_new_det bit%0d: got %b, required %b", i + 1, detector_out, (i == 2));
            else n_pass++;
        end
    endtask

    task automatic test_cfg_err();
        logic [3:0] err_req = 4'b1100;
        logic [3:0] det_req = 4'b0001;
        logic [3:0] s = 4'b1011;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      step(s[3], 1'b1, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0);
            else if (i == 1) step(s[2], 1'b1, 1'b1, 8'hFF, 4'd9, 1'b0, 1'b0);
            else             send(s[3-i]);
            n_checks++;
            if (cfg_err !== err_req[3-i] || detector_out !== det_req[3-i])
                $display("FAIL cfg_err step%0d: err=%b det=%b, required err=%b det=%b",
                         i, cfg_err, detector_out, err_req[3-i], det_req[3-i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            send(1'b1);
            n_checks++;
            if (detector_out !== 1'b1 || match_count !== CNT_W'((i < 6) ? i + 1 : 7) || count_sat !== (i >= 6))
                $display("FAIL saturate match%0d: det=%b cnt=%0d sat=%b, required det=1 cnt=%0d sat=%b",
                         i + 1, detector_out, match_count, count_sat, (i < 6) ? i + 1 : 7, (i >= 6));
            else n_pass++;
        end
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (detector_out !== 1'b1 || match_count !== 3'd0 || count_sat !== 1'b0)
            $display("FAIL clr_with_match: det=%b cnt=%0d sat=%b, required det=1 cnt=0 sat=0",
                     detector_out, match_count, count_sat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        n_checks++;
        if (detector_out !== 1'b1 || match_count !== 3'd1)
            $display("FAIL premid_match: det=%b cnt=%0d, required det=1 cnt=1", detector_out, match_count);
        else n_pass++;
        send(1'b1); send(1'b0); send(1'b1);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({detector_out, match_count, count_sat, cfg_err} !== '0)
            $display("FAIL async_reset: det=%b cnt=%0d sat=%b err=%b, required all 0",
                     detector_out, match_count, count_sat, cfg_err);
        else n_pass++;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        send(1'b1);
        n_checks++;
        if (detector_out !== 1'b0 || match_count !== 3'd0)
            $display("FAIL partial_lost: det=%b cnt=%0d, required det=0 cnt=0", detector_out, match_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic b, v, ld, ov, clr;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0] len;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            b   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 99) < 75);
            ld  = ($urandom_range(0, 99) < 4);
            clr = ($urandom_range(0, 99) < 4);
            ov  = 1'($urandom_range(0, 1));
            pat = MAX_LEN'($urandom);
            len = LEN_W'($urandom_range(0, 4) == 0 ? $urandom_range(0, MAX_LEN + 1) : $urandom_range(1, 4));
            step(b, v, ld, pat, len, ov, clr);
            n_checks++;
            if (detector_out !== exp_det || match_count !== exp_cnt || count_sat !== exp_sat || cfg_err !== exp_err)
                $display("FAIL random cycle%0d: det=%b cnt=%0d sat=%b err=%b, required det=%b cnt=%0d sat=%b err=%b",
                         c, detector_out, match_count, count_sat, cfg_err, exp_det, exp_cnt, exp_sat, exp_err);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_overlap();
        test_nonoverlap();
        test_gap();
        test_cfg_same_cycle();
        test_cfg_err();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
